// File: rtl/traffic_pkg.sv
// Shared definitions for the N-way traffic controller: phase encoding and
// the direction-index width rule.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_e;

  // A direction index is never narrower than one bit, even for two directions.
  function automatic int dir_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_next_dir.sv
// Round-robin pick of the next direction to serve, scanning upward from the
// active direction and visiting the active direction itself last.
module rr_next_dir
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR = 4,
  localparam int DIR_W   = dir_width(NUM_DIR)
) (
  input  logic [NUM_DIR-1:0] pending,
  input  logic [DIR_W-1:0]   active_dir,
  output logic [DIR_W-1:0]   next_dir,
  output logic               any_other_pending
);

  localparam logic [DIR_W:0] NUM_DIR_X = (DIR_W+1)'(NUM_DIR);

  always_comb begin
    logic [DIR_W:0] idx;
    logic           found;
    found = 1'b0;
    idx   = {1'b0, active_dir} + (DIR_W+1)'(1);
    if (idx >= NUM_DIR_X) idx = idx - NUM_DIR_X;
    // Fixed-time fallback when nothing is waiting.
    next_dir = idx[DIR_W-1:0];
    for (int k = 1; k <= NUM_DIR; k++) begin
      idx = {1'b0, active_dir} + (DIR_W+1)'(k);
      if (idx >= NUM_DIR_X) idx = idx - NUM_DIR_X;
      if (!found && pending[idx[DIR_W-1:0]]) begin
        found    = 1'b1;
        next_dir = idx[DIR_W-1:0];
      end
    end
  end

  assign any_other_pending = |(pending & ~(NUM_DIR'(1) << active_dir));

endmodule

// File: rtl/traffic_controller_nway.sv
// N-direction traffic signal controller: round-robin service of latched
// requests, rest-in-green, yellow/all-red clearance and emergency preemption.
module traffic_controller_nway
  import traffic_pkg::*;
#(
  parameter  int NUM_DIR      = 4,
  parameter  int CNT_W        = 24,
  parameter  int GREEN_TICKS  = 30,
  parameter  int YELLOW_TICKS = 3,
  parameter  int ALLRED_TICKS = 2,
  localparam int DIR_W        = dir_width(NUM_DIR)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [NUM_DIR-1:0] req,
  input  logic               preempt,
  input  logic [DIR_W-1:0]   preempt_dir,
  output logic [NUM_DIR-1:0] red,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] green,
  output logic [DIR_W-1:0]   active_dir,
  output logic [1:0]         phase,
  output logic               phase_start
);

  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ALLRED_TICKS - 1);

  phase_e             phase_q, phase_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [DIR_W-1:0]   dir_q, dir_n, rr_dir;
  logic [NUM_DIR-1:0] pend_q, pend_n, clr;
  logic               any_other, pre_ok, started_q, ps_q;

  rr_next_dir #(.NUM_DIR(NUM_DIR)) u_rr (
    .pending           (pend_q),
    .active_dir        (dir_q),
    .next_dir          (rr_dir),
    .any_other_pending (any_other)
  );

  // Out-of-range preemption targets are treated as no preemption at all.
  assign pre_ok = preempt && ({1'b0, preempt_dir} < (DIR_W+1)'(NUM_DIR));

  always_comb begin
    phase_n = phase_q;
    cnt_n   = cnt_q;
    dir_n   = dir_q;
    clr     = '0;
    if (en) begin
      case (phase_q)
        PH_GREEN: begin
          if (pre_ok && preempt_dir != dir_q) begin
            phase_n = PH_YELLOW;
            cnt_n   = '0;
          end else if (cnt_q == G_LAST) begin
            // Saturate and re-evaluate each tick while resting or held by preemption.
            if (!pre_ok && any_other) begin
              phase_n = PH_YELLOW;
              cnt_n   = '0;
            end
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        PH_YELLOW: begin
          if (cnt_q == Y_LAST) begin
            phase_n = PH_ALLRED;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        PH_ALLRED: begin
          if (cnt_q == A_LAST) begin
            phase_n = PH_GREEN;
            cnt_n   = '0;
            dir_n   = pre_ok ? preempt_dir : rr_dir;
            clr     = NUM_DIR'(1) << dir_n;
          end else begin
            cnt_n = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          phase_n = PH_ALLRED;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A request arriving on the clearing edge survives the clear.
  assign pend_n = (pend_q & ~clr) | req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q   <= PH_ALLRED;
      cnt_q     <= '0;
      dir_q     <= '0;
      pend_q    <= '0;
      started_q <= 1'b0;
      ps_q      <= 1'b0;
    end else begin
      phase_q   <= phase_n;
      cnt_q     <= cnt_n;
      dir_q     <= dir_n;
      pend_q    <= pend_n;
      started_q <= 1'b1;
      ps_q      <= !started_q || (phase_n != phase_q);
    end
  end

  for (genvar d = 0; d < NUM_DIR; d++) begin : g_lamp
    assign green[d]  = (phase_q == PH_GREEN)  && (dir_q == DIR_W'(d));
    assign yellow[d] = (phase_q == PH_YELLOW) && (dir_q == DIR_W'(d));
    assign red[d]    = !(green[d] || yellow[d]);
  end

  assign active_dir  = dir_q;
  assign phase       = phase_q;
  assign phase_start = ps_q;

endmodule

// File: tb/tb_traffic_controller_nway.sv
// Self-checking bench for traffic_controller_nway (5 directions, short phase
// lengths) against a rule-level behavioural model.
module tb_traffic_controller_nway;

  localparam int N  = 5;
  localparam int G  = 8;
  localparam int Y  = 3;
  localparam int A  = 2;
  localparam int DW = 3;
  localparam int OW = 3*N + DW + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b1;
  logic [N-1:0]  req = '0;
  logic          preempt = 1'b0;
  logic [DW-1:0] preempt_dir = '0;
  logic [N-1:0]  red, yellow, green;
  logic [DW-1:0] active_dir;
  logic [1:0]    phase;
  logic          phase_start;
  logic [OW-1:0] obs;

  int n_checks = 0;
  int n_fail = 0;

  // Model state: phase as 0 all-red / 1 green / 2 yellow, elapsed ticks, owner, pending set.
  int           m_ph, m_cnt, m_dir;
  logic [N-1:0] m_pend;
  logic         m_ps, m_started;

  always #5 clk = ~clk;

  assign obs = {red, yellow, green, active_dir, phase, phase_start};

  traffic_controller_nway #(
    .NUM_DIR(N), .CNT_W(24), .GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .preempt(preempt),
    .preempt_dir(preempt_dir), .red(red), .yellow(yellow), .green(green),
    .active_dir(active_dir), .phase(phase), .phase_start(phase_start)
  );

  function automatic int dur(input int ph);
    return (ph == 1) ? G : ((ph == 2) ? Y : A);
  endfunction

  function automatic int rr_pick();
    for (int k = 1; k <= N; k++)
      if (m_pend[(m_dir + k) % N]) return (m_dir + k) % N;
    return (m_dir + 1) % N;
  endfunction

  function automatic logic [OW-1:0] expected();
    logic [N-1:0] r, y, g;
    g = '0;
    y = '0;
    if (m_ph == 1) g[m_dir] = 1'b1;
    if (m_ph == 2) y[m_dir] = 1'b1;
    r = ~(g | y);
    return {r, y, g, DW'(m_dir), 2'(m_ph), m_ps};
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cnt = 0; m_dir = 0; m_pend = '0; m_ps = 1'b0; m_started = 1'b0;
  endtask

  task automatic model_step();
    int nph, nd;
    logic pre_ok, others, expire;
    logic [N-1:0] clr;
    nph = m_ph;
    nd = m_dir;
    clr = '0;
    pre_ok = preempt && (int'(preempt_dir) < N);
    others = 1'b0;
    for (int d = 0; d < N; d++) if (d != m_dir && m_pend[d]) others = 1'b1;
    expire = (m_cnt >= dur(m_ph) - 1);
    if (en) begin
      if (m_ph == 1) begin
        if ((pre_ok && int'(preempt_dir) != m_dir) || (expire && !pre_ok && others)) nph = 2;
      end else if (expire) begin
        nph = (m_ph == 2) ? 0 : 1;
        if (m_ph == 0) begin
          nd = pre_ok ? int'(preempt_dir) : rr_pick();
          clr[nd] = 1'b1;
        end
      end
      if (nph != m_ph) m_cnt = 0;
      else if (!expire) m_cnt++;
    end
    m_ps = !m_started || (nph != m_ph);
    m_started = 1'b1;
    m_pend = (m_pend & ~clr) | req;
    m_ph = nph;
    m_dir = nd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_step();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (red !== {N{1'b1}}) begin n_fail++; $display("FAIL reset_red: got %b want %b", red, {N{1'b1}}); end
    n_checks++; if (yellow !== '0) begin n_fail++; $display("FAIL reset_yellow: got %b want 0", yellow); end
    n_checks++; if (green !== '0) begin n_fail++; $display("FAIL reset_green: got %b want 0", green); end
    n_checks++; if (phase !== 2'b00) begin n_fail++; $display("FAIL reset_phase: got %b want 00", phase); end
    n_checks++; if (active_dir !== '0) begin n_fail++; $display("FAIL reset_dir: got %0d want 0", active_dir); end
    n_checks++; if (phase_start !== 1'b0) begin n_fail++; $display("FAIL reset_pstart: got %b want 0", phase_start); end
    reset = 1'b0;
  endtask

  task automatic test_startup();
    for (int i = 1; i <= 25; i++) begin
      req = (i == 11) ? 5'b00001 : 5'b00000;
      tick();
      req = '0;
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL startup cyc %0d: got %h want %h", i, obs, expected()); end
      if (i == 1) begin
        n_checks++; if (phase_start !== 1'b1 || phase !== 2'b00) begin n_fail++; $display("FAIL startup_allred: pstart %b phase %b want 1 00", phase_start, phase); end
      end
      if (i == 2 || i == 10) begin
        n_checks++; if (green !== 5'b00010) begin n_fail++; $display("FAIL startup_green1 cyc %0d: got %b want 00010", i, green); end
      end
      if (i == 12) begin
        n_checks++; if (yellow !== 5'b00010) begin n_fail++; $display("FAIL startup_yellow1: got %b want 00010", yellow); end
      end
      if (i == 17) begin
        n_checks++; if (green !== 5'b00001) begin n_fail++; $display("FAIL startup_green0: got %b want 00001", green); end
      end
    end
  endtask

  task automatic test_rotation();
    int order[$];
    logic ok;
    req = 5'b00111;
    tick();
    req = '0;
    n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL rotation start: got %h want %h", obs, expected()); end
    for (int i = 0; i < 60; i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL rotation cyc %0d: got %h want %h", i, obs, expected()); end
      if (phase_start && phase == 2'b01) order.push_back(int'(active_dir));
      ok = ($countones(green | yellow) <= 1);
      for (int d = 0; d < N; d++) if (int'(red[d]) + int'(yellow[d]) + int'(green[d]) != 1) ok = 1'b0;
      n_checks++; if (!ok) begin n_fail++; $display("FAIL lamp_invariant cyc %0d: r %b y %b g %b", i, red, yellow, green); end
    end
    n_checks++;
    if (order.size() != 3 || order[0] != 1 || order[1] != 2 || order[2] != 0) begin
      n_fail++; $display("FAIL rotation_order: got %p want '{1, 2, 0}", order);
    end
    n_checks++; if (phase !== 2'b01 || active_dir !== 3'd0) begin n_fail++; $display("FAIL rotation_rest: phase %b dir %0d want 01 0", phase, active_dir); end
  endtask

  task automatic test_wrap();
    req = 5'b10000;
    tick();
    req = '0;
    n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL wrap start: got %h want %h", obs, expected()); end
    for (int i = 0; i < 40 && !(phase_start && green[4]); i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL wrap cyc %0d: got %h want %h", i, obs, expected()); end
    end
    n_checks++; if (green[4] !== 1'b1) begin n_fail++; $display("FAIL wrap_reach4: green %b want 10000", green); end
    req = 5'b00001;
    tick();
    req = '0;
    n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL wrap pulse: got %h want %h", obs, expected()); end
    for (int i = 0; i < 40 && !(phase_start && phase == 2'b01); i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL wrap2 cyc %0d: got %h want %h", i, obs, expected()); end
    end
    n_checks++; if (green !== 5'b00001 || active_dir !== 3'd0) begin n_fail++; $display("FAIL wrap_to0: green %b dir %0d want 00001 0", green, active_dir); end
  endtask

  task automatic test_preempt();
    req = 5'b00011;
    tick();
    req = '0;
    for (int i = 0; i < 60 && !(phase_start && green[0]); i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL preempt wait cyc %0d: got %h want %h", i, obs, expected()); end
    end
    n_checks++; if (green[0] !== 1'b1) begin n_fail++; $display("FAIL preempt_reach0: green %b want 00001", green); end
    tick();
    preempt = 1'b1;
    preempt_dir = 3'd2;
    req = 5'b00010;
    for (int i = 1; i <= 18; i++) begin
      tick();
      req = '0;
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL preempt cyc %0d: got %h want %h", i, obs, expected()); end
      if (i == 1) begin
        n_checks++; if (yellow !== 5'b00001) begin n_fail++; $display("FAIL preempt_yellow0: got %b want 00001", yellow); end
      end
      if (i == 4) begin
        n_checks++; if (phase !== 2'b00) begin n_fail++; $display("FAIL preempt_allred: got %b want 00", phase); end
      end
      if (i == 6 || i == 18) begin
        n_checks++; if (green !== 5'b00100) begin n_fail++; $display("FAIL preempt_green2 cyc %0d: got %b want 00100", i, green); end
      end
    end
    preempt = 1'b0;
    tick();
    n_checks++; if (yellow !== 5'b00100) begin n_fail++; $display("FAIL preempt_release: yellow %b want 00100", yellow); end
    n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL preempt release: got %h want %h", obs, expected()); end
  endtask

  task automatic test_enable();
    int len;
    for (int i = 0; i < 30 && !(phase_start && phase == 2'b01); i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL enable wait cyc %0d: got %h want %h", i, obs, expected()); end
    end
    en = 1'b0;
    req = 5'b01000;
    len = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      req = '0;
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL enable cyc %0d: got %h want %h", i, obs, expected()); end
      if (phase != 2'b01) break;
      len++;
      en = ~en;
    end
    en = 1'b1;
    n_checks++; if (len != 16) begin n_fail++; $display("FAIL enable_green_len: got %0d want 16", len); end
    for (int i = 0; i < 30 && !(phase_start && phase == 2'b01); i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL enable wait2 cyc %0d: got %h want %h", i, obs, expected()); end
    end
    n_checks++; if (active_dir !== 3'd3 || green !== 5'b01000) begin n_fail++; $display("FAIL enable_req_latched: dir %0d green %b want 3 01000", active_dir, green); end
  endtask

  task automatic test_reset_mid();
    req = 5'b10100;
    tick();
    req = '0;
    for (int i = 0; i < 30 && phase != 2'b10; i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL rstmid wait cyc %0d: got %h want %h", i, obs, expected()); end
    end
    tick();
    n_checks++; if (phase !== 2'b10) begin n_fail++; $display("FAIL rstmid_in_yellow: phase %b want 10", phase); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++; if (red !== {N{1'b1}} || yellow !== '0 || green !== '0) begin n_fail++; $display("FAIL rstmid_lamps: r %b y %b g %b want 11111 0 0", red, yellow, green); end
    n_checks++; if (phase !== 2'b00 || active_dir !== '0) begin n_fail++; $display("FAIL rstmid_state: phase %b dir %0d want 00 0", phase, active_dir); end
    tick();
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL rstmid cyc %0d: got %h want %h", i, obs, expected()); end
      if (i == 1) begin
        n_checks++; if (phase !== 2'b00 || phase_start !== 1'b1) begin n_fail++; $display("FAIL rstmid_allred: phase %b pstart %b want 00 1", phase, phase_start); end
      end
      if (i == 2) begin
        n_checks++; if (green !== 5'b00010) begin n_fail++; $display("FAIL rstmid_green1: got %b want 00010", green); end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(0, 9) != 0);
      req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 29) == 0) begin
        preempt = ~preempt;
        preempt_dir = DW'($urandom_range(0, 7));
      end
      tick();
      n_checks++; if (obs !== expected()) begin n_fail++; $display("FAIL random cyc %0d: got %h want %h", i, obs, expected()); end
      n_checks++; if (int'(active_dir) >= N) begin n_fail++; $display("FAIL random_dir_range cyc %0d: got %0d want < %0d", i, active_dir, N); end
    end
    preempt = 1'b0;
    en = 1'b1;
    req = '0;
  endtask

  initial begin
    test_reset();
    test_startup();
    test_rotation();
    test_wrap();
    test_preempt();
    test_enable();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
